// File: rtl/auto_driver.sv
// Autonomous right-hand-rule maze walker: debounces the four obstacle detectors
// and drives Engine command levels from a timed Moore FSM.
module auto_driver #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int STOP_CYCLES     = 50_000_000,
    parameter int TURN_CYCLES     = 90_000_000,
    parameter int SETTLE_CYCLES   = 60_000_000,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       front_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    input  logic       back_detector,
    output logic       throttle,
    output logic       clutch,
    output logic       brake,
    output logic       reverse,
    output logic       left,
    output logic       right,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FORWARD   = 3'd1,
        STOP      = 3'd2,
        TURN_R    = 3'd3,
        TURN_L    = 3'd4,
        TURN_BACK = 3'd5,
        SETTLE    = 3'd6,
        STUCK     = 3'd7
    } state_e;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_TERM     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_TERM   = CNT_W'(STOP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_TERM   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACK_TERM   = CNT_W'(2 * TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);

    // bit order everywhere: 0 front, 1 left, 2 right, 3 back
    logic [3:0]      raw_s;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      det_q, det_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic throttle_q, throttle_d, clutch_q, clutch_d, brake_q, brake_d;
    logic left_q, left_d, right_q, right_d;

    assign raw_s = {back_detector, right_detector, left_detector, front_detector};

    // Debounce: a synchronised value must differ from det for DEBOUNCE_CYCLES edges in a row
    always_comb begin
        det_d = det_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] == det_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] >= DB_TERM) begin
                det_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Next-state logic for the maze walker
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FORWARD;
                FORWARD: begin
                    if (det_q[0] || !det_q[2] || !det_q[1]) state_d = STOP;
                    else                                    state_d = FORWARD;
                end
                STOP: begin
                    if (cnt_q >= STOP_TERM) begin
                        if      (!det_q[2]) state_d = TURN_R;
                        else if (!det_q[0]) state_d = SETTLE;
                        else if (!det_q[1]) state_d = TURN_L;
                        else if (!det_q[3]) state_d = TURN_BACK;
                        else                state_d = STUCK;
                    end else begin
                        state_d = STOP;
                    end
                end
                TURN_R, TURN_L: begin
                    if (cnt_q >= TURN_TERM) state_d = SETTLE;
                    else                    state_d = state_q;
                end
                TURN_BACK: begin
                    if (cnt_q >= BACK_TERM) state_d = SETTLE;
                    else                    state_d = TURN_BACK;
                end
                SETTLE: begin
                    // only a blocked front matters here; side openings are masked
                    if      (det_q[0])              state_d = STOP;
                    else if (cnt_q >= SETTLE_TERM)  state_d = FORWARD;
                    else                            state_d = SETTLE;
                end
                STUCK: begin
                    if (det_q != 4'b1111) state_d = STOP;
                    else                  state_d = STUCK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Phase counter and Moore output decode of the next state
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        throttle_d = 1'b0;
        clutch_d   = 1'b0;
        brake_d    = 1'b0;
        left_d     = 1'b0;
        right_d    = 1'b0;
        case (state_d)
            FORWARD, SETTLE: throttle_d = 1'b1;
            STOP, STUCK: begin
                brake_d  = 1'b1;
                clutch_d = 1'b1;
            end
            TURN_R:            right_d = 1'b1;
            TURN_L, TURN_BACK: left_d  = 1'b1;
            default:           throttle_d = 1'b0;
        endcase
    end

    // Detector synchroniser and debounce state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            det_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            det_q   <= det_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // FSM state, phase counter and registered command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            throttle_q <= 1'b0;
            clutch_q   <= 1'b0;
            brake_q    <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            throttle_q <= throttle_d;
            clutch_q   <= clutch_d;
            brake_q    <= brake_d;
            left_q     <= left_d;
            right_q    <= right_d;
        end
    end

    assign throttle = throttle_q;
    assign clutch   = clutch_q;
    assign brake    = brake_q;
    assign reverse  = 1'b0;
    assign left     = left_q;
    assign right    = right_q;
    assign state_o  = state_q;

endmodule
